// File: rtl/puf_eval_ctrl.sv
// puf_eval_ctrl: sequences a 4-challenge ring-oscillator PUF evaluation.
// Each challenge runs clear -> measure -> settle -> capture. The four 2-bit
// responses are collected in a shadow register. The shadow reaches the
// fingerprint in one step, together with the done pulse, so a reader never
// observes a partially updated fingerprint.
module puf_eval_ctrl #(
  parameter int unsigned CLEAR_CYCLES  = 2,
  parameter int unsigned MEAS_CYCLES   = 1000,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] puf_response,
  output logic [1:0] puf_chal,
  output logic       puf_enable,
  output logic       puf_reset,
  output logic       busy,
  output logic       done,
  output logic [7:0] fingerprint,
  output logic       fp_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_SETTLE,
    S_CAPTURE,
    S_DONE
  } state_t;

  // Timer reload values: a phase of N cycles counts N-1 down to 0.
  localparam logic [15:0] CLEAR_LOAD  = 16'(CLEAR_CYCLES - 1);
  localparam logic [15:0] MEAS_LOAD   = 16'(MEAS_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] timer, timer_next;
  logic [1:0]  index, index_next;
  logic [1:0]  sync_q1, resp_sync;
  logic [7:0]  shadow;
  logic        enable_next, clear_next, busy_next, done_next;

  // Two-flop synchronizer for the PUF response, which is asynchronous to clk.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1   <= '0;
      resp_sync <= '0;
    end else begin
      sync_q1   <= puf_response;
      resp_sync <= sync_q1;
    end
  end

  // Next-state, timer reload and output decode for the evaluation sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next = state;
    timer_next = timer;
    index_next = index;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_CLEAR;
          index_next = 2'd0;
          timer_next = CLEAR_LOAD;
        end
      end
      S_CLEAR: begin
        if (timer == 16'd0) begin
          state_next = S_RUN;
          timer_next = MEAS_LOAD;
        end else begin
          timer_next = timer - 16'd1;
        end
      end
      S_RUN: begin
        if (timer == 16'd0) begin
          state_next = S_SETTLE;
          timer_next = SETTLE_LOAD;
        end else begin
          timer_next = timer - 16'd1;
        end
      end
      S_SETTLE: begin
        if (timer == 16'd0) begin
          state_next = S_CAPTURE;
          timer_next = 16'd0;
        end else begin
          timer_next = timer - 16'd1;
        end
      end
      S_CAPTURE: begin
        if (index == 2'd3) begin
          state_next = S_DONE;
        end else begin
          state_next = S_CLEAR;
          index_next = index + 2'd1;
          timer_next = CLEAR_LOAD;
        end
      end
      S_DONE: begin
        // start is deliberately not sampled here; a held start is seen in IDLE.
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // The PUF-facing controls are decoded from the next state and then
    // registered. This keeps them glitch-free and aligned with the state.
    enable_next = (state_next == S_RUN);
    clear_next  = (state_next == S_IDLE) || (state_next == S_CLEAR) || (state_next == S_DONE);
    busy_next   = (state_next == S_CLEAR) || (state_next == S_RUN) ||
                  (state_next == S_SETTLE) || (state_next == S_CAPTURE);
    done_next   = (state_next == S_DONE);
  end

  // State, phase timer, challenge index and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      timer      <= '0;
      index      <= '0;
      puf_enable <= 1'b0;
      puf_reset  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      index      <= index_next;
      puf_enable <= enable_next;
      puf_reset  <= clear_next;
      busy       <= busy_next;
      done       <= done_next;
    end
  end

  // Capture each response into the shadow register. On the last capture,
  // publish the full result so that it appears in the same cycle as done.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shadow      <= '0;
      fingerprint <= '0;
      fp_valid    <= 1'b0;
    end else if (state == S_CAPTURE) begin
      shadow[{index, 1'b0} +: 2] <= resp_sync;
      if (index == 2'd3) begin
        fingerprint <= {resp_sync, shadow[5:0]};
        fp_valid    <= 1'b1;
      end
    end
  end

  // The challenge follows the index, so it is stable from CLEAR through CAPTURE.
  assign puf_chal = index;

endmodule

// File: doc/puf_eval_ctrl.md
PUF_EVAL_CTRL -- requirements
Module: puf_eval_ctrl

Interface
REQ-001 SHALL have parameter CLEAR_CYCLES, default 2, meaning the cycles puf_reset is held per challenge (legal 1..65535).
REQ-002 SHALL have parameter MEAS_CYCLES, default 1000, meaning the cycles puf_enable is held high per challenge (legal 1..65535).
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, meaning the cycles waited after enable drops before capture (legal 3..65535).
REQ-004 SHALL have port: clk  input  1  the single clock; all state is in this domain.
REQ-005 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port: start  input  1  request one full 4-challenge evaluation; sampled on the rising edge of clk.
REQ-007 SHALL have port: puf_response  input  2  response from the PUF array, asynchronous to clk.
REQ-008 SHALL have port: puf_chal  output  2  challenge driven to the PUF.
REQ-009 SHALL have port: puf_enable  output  1  ring-oscillator enable to the PUF.
REQ-010 SHALL have port: puf_reset  output  1  active-high clear for the PUF counters and comparators.
REQ-011 SHALL have port: busy  output  1  high while an evaluation is in progress.
REQ-012 SHALL have port: done  output  1  one-cycle pulse when the fingerprint is updated.
REQ-013 SHALL have port: fingerprint  output  8  last completed result; bits [2i+1:2i] hold the response to challenge i.
REQ-014 SHALL have port: fp_valid  output  1  sticky; high after the first done until reset.

Function
REQ-015 SHALL pass puf_response through a 2-flop synchronizer before any use.
REQ-016 SHALL implement FSM states IDLE, CLEAR, RUN, SETTLE, CAPTURE, DONE, plus a 16-bit phase timer and a 2-bit challenge index.
REQ-017 IDLE: on start=1, SHALL go to CLEAR with index=0; busy rises in the same edge.
REQ-018 CLEAR: SHALL hold puf_reset=1 and puf_enable=0 for exactly CLEAR_CYCLES cycles, then go to RUN.
REQ-019 RUN: SHALL hold puf_reset=0 and puf_enable=1 for exactly MEAS_CYCLES cycles, then go to SETTLE.
REQ-020 SETTLE: SHALL hold puf_enable=0 and puf_reset=0 for exactly SETTLE_CYCLES cycles, then go to CAPTURE.
REQ-021 CAPTURE (1 cycle): SHALL write the synchronized response into shadow bits [2*index+1:2*index].
REQ-022 In CAPTURE, if index<3, SHALL increment index and go to CLEAR; if index=3, SHALL go to DONE.
REQ-023 DONE (1 cycle): SHALL copy the shadow into fingerprint, pulse done=1, set fp_valid=1, deassert busy, and go to IDLE.
REQ-024 SHALL drive puf_chal = index at all times, so the challenge is stable from CLEAR through CAPTURE.
REQ-025 Per-challenge duration SHALL be CLEAR_CYCLES+MEAS_CYCLES+SETTLE_CYCLES+1 cycles.
REQ-026 With start sampled at edge 0, done SHALL be high in cycle 4*(CLEAR_CYCLES+MEAS_CYCLES+SETTLE_CYCLES+1)+1.
REQ-027 fingerprint SHALL change only in DONE; it is never partially updated.
REQ-028 start SHALL be ignored while busy=1 and during DONE; it is not queued.
REQ-029 start held high continuously SHALL restart an evaluation the cycle after DONE (back-to-back).
REQ-030 In IDLE, SHALL drive puf_reset=1 and puf_enable=0.
REQ-031 The phase timer SHALL reload at every state entry; no wrap-around occurs within legal parameters.

Reset
REQ-032 While reset=0, SHALL asynchronously force: state=IDLE, index=0, puf_chal=0, puf_enable=0, puf_reset=1, busy=0, done=0, fingerprint=0, fp_valid=0, shadow=0, synchronizer=0.
REQ-033 Reset asserted mid-evaluation SHALL discard the partial result; after release, the block waits for a new start.

Verification (CLEAR=2, MEAS=8, SETTLE=3; 14 cycles per challenge)
REQ-034 Responses per challenge 0..3 = 2'b01, 2'b10, 2'b11, 2'b00, single start -> done in cycle 57, fingerprint=8'h39, fp_valid=1, busy low in cycle 57.
REQ-035 Waveform check of one evaluation -> puf_enable high exactly 8 cycles per challenge, puf_chal sequence 0,1,2,3, puf_reset high 2 cycles before each RUN.
REQ-036 start pulsed at cycle 20 during busy -> ignored; exactly one done pulse at cycle 57.
REQ-037 reset asserted at cycle 30 -> all outputs at reset values immediately; a new start gives a full 57-cycle run with fingerprint=8'h39.
REQ-038 start held high -> second evaluation begins the cycle after done; fingerprint stays 8'h39 until the second done.
REQ-039 puf_response toggled only outside CAPTURE minus 2 cycles -> captured values equal the level stable at capture; no metastable X propagates.
